// File: rtl/loader_pkg.sv
// Shared types and default constants for the instruction-memory program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } loader_state_e;

  localparam int unsigned LOADER_DEPTH     = 128;
  localparam logic [15:0] LOADER_HALT_WORD = 16'h5000;
  localparam int unsigned ADDR_W           = 7;
  localparam int unsigned CNT_W            = 8;

endpackage

// File: rtl/loader_checksum.sv
// 16-bit wrapping accumulator used to verify a loaded image.
// Only present when LOADER_CHECKSUM_EN is defined.
`ifdef LOADER_CHECKSUM_EN
module loader_checksum (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        add_i,
  input  logic [15:0] data_i,
  output logic [15:0] sum_o
);

  logic [15:0] sum_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q <= 16'h0000;
    end else if (clr_i) begin
      sum_q <= 16'h0000;
    end else if (add_i) begin
      sum_q <= sum_q + data_i;
    end
  end

  assign sum_o = sum_q;

endmodule
`endif

// File: rtl/program_loader.sv
// Streams instruction words into instruction memory while holding the CPU in reset.
// Define LOADER_CHECKSUM_EN to require a trailing checksum word after HALT_WORD.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH     = LOADER_DEPTH,
  parameter logic [15:0] HALT_WORD = LOADER_HALT_WORD
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [15:0]       in_data_i,
  output logic              in_ready_o,
  output logic              im_wr_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [15:0]       im_data_o,
  output logic              cpu_reset_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic              chk_err_o,
  output logic [CNT_W-1:0]  word_count_o,
  output logic [2:0]        state_o
);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_LOAD  = LOAD;
  localparam logic [2:0] ST_CHECK = CHECK;
  localparam logic [2:0] ST_DONE  = DONE;
  localparam logic [2:0] ST_ERR   = ERR;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(DEPTH);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              in_ready, xfer, restart;

  assign in_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign xfer     = in_valid_i && in_ready;
  assign restart  = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));

`ifdef LOADER_CHECKSUM_EN
  logic        chk_q, chk_d;
  logic [15:0] sum;

  loader_checksum u_checksum (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (restart),
    .add_i (xfer && (state_q == ST_LOAD)),
    .data_i(in_data_i),
    .sum_o (sum)
  );
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
`ifdef LOADER_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (restart) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          chk_d   = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          wr_d   = 1'b1;
          addr_d = ptr_q;
          data_d = in_data_i;
          // Pointer parks on the last address instead of wrapping.
          if (ptr_q != LAST_ADDR) ptr_d = ptr_q + 1'b1;
          if (cnt_q != MAX_CNT)   cnt_d = cnt_q + 1'b1;
          if (in_data_i == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_DONE;
            done_d  = 1'b1;
`endif
          end else if (ptr_q == LAST_ADDR) begin
            state_d = ST_ERR;
            ovf_d   = 1'b1;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer) begin
          if (in_data_i == sum) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERR;
            chk_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) chk_q <= 1'b0;
    else       chk_q <= chk_d;
  end
  assign chk_err_o = chk_q;
`else
  assign chk_err_o = 1'b0;
`endif

  assign in_ready_o   = in_ready;
  assign im_wr_o      = wr_q;
  assign im_addr_o    = addr_q;
  assign im_data_o    = data_q;
  assign cpu_reset_o  = (state_q == ST_LOAD) || (state_q == ST_CHECK) || (state_q == ST_ERR);
  assign done_o       = done_q;
  assign overflow_o   = ovf_q;
  assign word_count_o = cnt_q;
  assign state_o      = state_q;

endmodule
